// File: rtl/id_stage_pkg.sv
// Shared constants and control bundle for the instruction-decode stage.
package id_stage_pkg;

   localparam int unsigned RW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_XOR = 3'b100;
   localparam logic [2:0] ALUC_SLL = 3'b101;
   localparam logic [2:0] ALUC_SRL = 3'b110;
   localparam logic [2:0] ALUC_LUI = 3'b111;

   localparam logic [1:0] PCSRC_PC4 = 2'b00;
   localparam logic [1:0] PCSRC_BPC = 2'b01;
   localparam logic [1:0] PCSRC_JPC = 2'b10;

   typedef struct packed {
      logic       wreg;
      logic       wmem;
      logic       m2reg;
      logic       aluimm;
      logic       shift;
      logic       sext;
      logic       rdst;
      logic       use_rs;
      logic       use_rt;
      logic       is_beq;
      logic       is_bne;
      logic       is_j;
      logic [2:0] aluc;
   } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports, one posedge write port, async clear; r0 stays zero.
module id_regfile
   import id_stage_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned DW   = 32
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic [RW-1:0] rna,
   input  logic [RW-1:0] rnb,
   input  logic [RW-1:0] wn,
   input  logic          we,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] qa,
   output logic [DW-1:0] qb
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      end else if (we && (wn != '0)) begin
         regs[wn] <= wd;
      end
   end

   assign qa = regs[rna];
   assign qb = regs[rnb];

endmodule

// File: rtl/id_stage.sv
// Instruction decode: control decode, operand forwarding, load-use stall and branch resolution.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned DW   = 32
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic [31:0]   id_inst,
   input  logic [DW-1:0] id_pc4,
   input  logic [RW-1:0] exe_rn,
   input  logic          exe_wreg,
   input  logic          exe_m2reg,
   input  logic [DW-1:0] exe_alu,
   input  logic [RW-1:0] mem_rn,
   input  logic          mem_wreg,
   input  logic          mem_m2reg,
   input  logic [DW-1:0] mem_alu,
   input  logic [DW-1:0] mem_mo,
   input  logic [RW-1:0] wb_rn,
   input  logic          wb_wreg,
   input  logic [DW-1:0] wb_wdata,
   output logic          id_m2reg,
   output logic          id_wmem,
   output logic          id_aluimm,
   output logic          id_shift,
   output logic          id_wreg,
   output logic [2:0]    id_aluc,
   output logic [DW-1:0] id_ra,
   output logic [DW-1:0] id_rb,
   output logic [DW-1:0] id_imm,
   output logic [RW-1:0] id_rn,
   output logic          wpcir,
   output logic [1:0]    pcsource,
   output logic [DW-1:0] bpc,
   output logic [DW-1:0] jpc
);

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [RW-1:0] rs;
   logic [RW-1:0] rt;
   logic [RW-1:0] rd;
   logic [15:0]   imm16;
   logic [DW-1:0] imm_s;
   logic [DW-1:0] rf_a;
   logic [DW-1:0] rf_b;
   logic          stall;
   ctrl_t         dec;

   assign op    = id_inst[31:26];
   assign rs    = id_inst[25:21];
   assign rt    = id_inst[20:16];
   assign rd    = id_inst[15:11];
   assign funct = id_inst[5:0];
   assign imm16 = id_inst[15:0];

   id_regfile #(.NREG(NREG), .DW(DW)) u_rf (
      .clk (clk),
      .clrn(clrn),
      .rna (rs),
      .rnb (rt),
      .wn  (wb_rn),
      .we  (wb_wreg),
      .wd  (wb_wdata),
      .qa  (rf_a),
      .qb  (rf_b)
   );

   // Decode; anything unrecognised falls through as an all-zero nop.
   always_comb begin
      dec = '0;
      case (op)
         OP_RTYPE: begin
            dec.wreg   = 1'b1;
            dec.rdst   = 1'b1;
            dec.use_rs = 1'b1;
            dec.use_rt = 1'b1;
            case (funct)
               FN_ADD:  dec.aluc = ALUC_ADD;
               FN_SUB:  dec.aluc = ALUC_SUB;
               FN_AND:  dec.aluc = ALUC_AND;
               FN_OR:   dec.aluc = ALUC_OR;
               FN_XOR:  dec.aluc = ALUC_XOR;
               FN_SLL:  begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; dec.use_rs = 1'b0; end
               FN_SRL:  begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; dec.use_rs = 1'b0; end
               default: dec = '0;
            endcase
         end
         OP_ADDI: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; dec.sext = 1'b1; dec.use_rs = 1'b1; end
         OP_ANDI: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; dec.use_rs = 1'b1; dec.aluc = ALUC_AND; end
         OP_ORI:  begin dec.wreg = 1'b1; dec.aluimm = 1'b1; dec.use_rs = 1'b1; dec.aluc = ALUC_OR; end
         OP_XORI: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; dec.use_rs = 1'b1; dec.aluc = ALUC_XOR; end
         OP_LUI:  begin dec.wreg = 1'b1; dec.aluimm = 1'b1; dec.aluc = ALUC_LUI; end
         OP_LW: begin
            dec.wreg   = 1'b1;
            dec.m2reg  = 1'b1;
            dec.aluimm = 1'b1;
            dec.sext   = 1'b1;
            dec.use_rs = 1'b1;
         end
         OP_SW: begin
            dec.wmem   = 1'b1;
            dec.aluimm = 1'b1;
            dec.sext   = 1'b1;
            dec.use_rs = 1'b1;
            dec.use_rt = 1'b1;
         end
         OP_BEQ: begin dec.is_beq = 1'b1; dec.sext = 1'b1; dec.use_rs = 1'b1; dec.use_rt = 1'b1; dec.aluc = ALUC_SUB; end
         OP_BNE: begin dec.is_bne = 1'b1; dec.sext = 1'b1; dec.use_rs = 1'b1; dec.use_rt = 1'b1; dec.aluc = ALUC_SUB; end
         OP_J:    dec.is_j = 1'b1;
         default: dec = '0;
      endcase
   end

   // Operand select: EXE ALU result, then MEM, then WB bypass, then the regfile.
   always_comb begin
      id_ra = rf_a;
      if (rs == '0)                                           id_ra = '0;
      else if (exe_wreg && !exe_m2reg && (exe_rn == rs))     id_ra = exe_alu;
      else if (mem_wreg && (mem_rn == rs))                    id_ra = mem_m2reg ? mem_mo : mem_alu;
      else if (wb_wreg && (wb_rn == rs))                      id_ra = wb_wdata;
   end

   always_comb begin
      id_rb = rf_b;
      if (rt == '0)                                           id_rb = '0;
      else if (exe_wreg && !exe_m2reg && (exe_rn == rt))     id_rb = exe_alu;
      else if (mem_wreg && (mem_rn == rt))                    id_rb = mem_m2reg ? mem_mo : mem_alu;
      else if (wb_wreg && (wb_rn == rt))                      id_rb = wb_wdata;
   end

   // A load in EXE cannot forward yet; reset forces the stall away.
   assign stall = clrn && exe_wreg && exe_m2reg && (exe_rn != '0) &&
                  ((dec.use_rs && (exe_rn == rs)) || (dec.use_rt && (exe_rn == rt)));

   assign wpcir     = !stall;
   assign id_wreg   = clrn && dec.wreg && !stall;
   assign id_wmem   = clrn && dec.wmem && !stall;
   assign id_m2reg  = clrn && dec.m2reg;
   assign id_aluimm = dec.aluimm;
   assign id_shift  = dec.shift;
   assign id_aluc   = dec.aluc;
   assign id_rn     = dec.rdst ? rd : rt;

   assign imm_s  = {{(DW-16){imm16[15]}}, imm16};
   assign id_imm = dec.sext ? imm_s : {{(DW-16){1'b0}}, imm16};
   assign bpc    = id_pc4 + {imm_s[DW-3:0], 2'b00};
   assign jpc    = {id_pc4[DW-1:DW-4], id_inst[25:0], 2'b00};

   always_comb begin
      pcsource = PCSRC_PC4;
      if (clrn && !stall) begin
         if (dec.is_j)
            pcsource = PCSRC_JPC;
         else if ((dec.is_beq && (id_ra == id_rb)) || (dec.is_bne && (id_ra != id_rb)))
            pcsource = PCSRC_BPC;
      end
   end

endmodule
